// File: rtl/apb_gpio_port.sv
// apb_gpio_port: APB GPIO port with direction control, synchronised inputs and edge interrupts
module apb_gpio_port #(
    parameter int          nPORT = 8,
    parameter int          nDATA = 16,
    parameter logic [15:0] BASE  = 16'h0100
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             PSEL,
    input  logic             PENABLE,
    input  logic             PWRITE,
    input  logic [15:0]      PADDR,
    input  logic [nDATA-1:0] PWDATA,
    output logic [nDATA-1:0] PRDATA,
    output logic             PREADY,
    output logic             PSLVERR,
    input  logic [nPORT-1:0] PORT_IN,
    output logic [nPORT-1:0] PORT_OUT,
    output logic [nPORT-1:0] PORT_OE,
    output logic             IRQ
);
    typedef enum logic [1:0] {IDLE, WAIT, ACC} state_t;
    state_t state;
    logic [nPORT-1:0] out_q, dir_q, ien_q, istat_q, edge_sel;
    logic [nPORT-1:0] sync1, sync2, prev;
    logic [nPORT-1:0] wd, ev, rd, ien_next, istat_next;
    logic [2:0] off;
    logic hit, wr, err, unused_bits;
    assign off         = PADDR[2:0];
    assign hit         = PADDR[15:3] == BASE[15:3];
    assign wr          = state == ACC && PWRITE;
    assign wd          = PWDATA[nPORT-1:0];
    assign unused_bits = ^PWDATA;
    assign err         = (off == 3'd1 && PWRITE) || off[2:1] == 2'b11;
    assign ev          = (edge_sel & ~sync2 & prev) | (~edge_sel & sync2 & ~prev);
    assign ien_next    = wr && off == 3'd3 ? wd : ien_q;
    assign istat_next  = (istat_q & ~(wr && off == 3'd4 ? wd : '0)) | ev;
    assign PORT_OUT    = out_q;
    assign PORT_OE     = dir_q;
    // register read mux, sampled into PRDATA during the wait cycle
    always_comb
        rd = off == 3'd0 ? out_q :
             off == 3'd1 ? sync2 :
             off == 3'd2 ? dir_q :
             off == 3'd3 ? ien_q :
             off == 3'd4 ? istat_q :
             off == 3'd5 ? edge_sel : '0;
    // APB handshake: setup decoded in IDLE, one wait cycle, then one ready cycle
    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            state   <= IDLE;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
        end else case (state)
            IDLE: state <= PSEL && !PENABLE && hit ? WAIT : IDLE;
            WAIT: if (PSEL && PENABLE) begin
                state   <= ACC;
                PREADY  <= 1'b1;
                PSLVERR <= err;
                PRDATA  <= nDATA'(rd);
            end else state <= IDLE;
            default: begin
                state   <= IDLE;
                PREADY  <= 1'b0;
                PSLVERR <= 1'b0;
            end
        endcase
    // control/status registers; writes commit on the ready-cycle edge, new events beat W1C
    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            out_q    <= '0;
            dir_q    <= '0;
            ien_q    <= '0;
            istat_q  <= '0;
            edge_sel <= '0;
            IRQ      <= 1'b0;
        end else begin
            if (wr && off == 3'd0) out_q <= wd;
            if (wr && off == 3'd2) dir_q <= wd;
            if (wr && off == 3'd5) edge_sel <= wd;
            ien_q   <= ien_next;
            istat_q <= istat_next;
            IRQ     <= |(istat_next & ien_next);
        end
    // two-flop input synchroniser plus one history flop for edge detection
    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= PORT_IN;
            sync2 <= sync1;
            prev  <= sync2;
        end
endmodule

// File: tb/tb_apb_gpio_port.sv
// tb_apb_gpio_port: directed table-driven bench for apb_gpio_port
module tb_apb_gpio_port;
    logic CLK = 1'b0, RST = 1'b0, PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [15:0] PADDR = '0, PWDATA = '0, PRDATA;
    logic PREADY, PSLVERR, IRQ;
    logic [7:0] PORT_IN = 8'hFF, PORT_OUT, PORT_OE;
    int checks = 0, failures = 0;

    apb_gpio_port dut (
        .CLK(CLK), .RST(RST), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .PORT_IN(PORT_IN), .PORT_OUT(PORT_OUT),
        .PORT_OE(PORT_OE), .IRQ(IRQ)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        w;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] rd;
        logic        err;
        int          rc;
        logic [7:0]  out;
        logic [7:0]  oe;
    } vec_t;
    vec_t tbl[19];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // one APB transfer started at posedge+1; rc is the 1-based cycle where PREADY was seen, 0 if never in 5 cycles
    task automatic apb(input logic w, input logic [15:0] a, input logic [15:0] d,
                       output logic [15:0] rd, output logic e, output int rc);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d;
        rc = 0; rd = '0; e = 1'b0;
        for (int c = 1; c <= 5 && rc == 0; c++) begin
            if (PREADY) begin
                rc = c; rd = PRDATA; e = PSLVERR;
            end
            tick(1);
            PENABLE = 1'b1;
        end
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    logic [15:0] rd;
    logic e;
    int rc;

    initial begin
        tbl[0]  = '{1'b0, 16'h0101, 16'h0000, 16'h00FF, 1'b0, 3, 8'h00, 8'h00};
        tbl[1]  = '{1'b1, 16'h0100, 16'h00A5, 16'h0000, 1'b0, 3, 8'hA5, 8'h00};
        tbl[2]  = '{1'b0, 16'h0100, 16'h0000, 16'h00A5, 1'b0, 3, 8'hA5, 8'h00};
        tbl[3]  = '{1'b1, 16'h0101, 16'h0000, 16'h0000, 1'b1, 3, 8'hA5, 8'h00};
        tbl[4]  = '{1'b0, 16'h0101, 16'h0000, 16'h00FF, 1'b0, 3, 8'hA5, 8'h00};
        tbl[5]  = '{1'b0, 16'h0107, 16'h0000, 16'h0000, 1'b1, 3, 8'hA5, 8'h00};
        tbl[6]  = '{1'b1, 16'h0106, 16'hFFFF, 16'h0000, 1'b1, 3, 8'hA5, 8'h00};
        tbl[7]  = '{1'b1, 16'h0102, 16'h003C, 16'h0000, 1'b0, 3, 8'hA5, 8'h3C};
        tbl[8]  = '{1'b0, 16'h0102, 16'h0000, 16'h003C, 1'b0, 3, 8'hA5, 8'h3C};
        tbl[9]  = '{1'b1, 16'h0100, 16'hFF5A, 16'h0000, 1'b0, 3, 8'h5A, 8'h3C};
        tbl[10] = '{1'b0, 16'h0100, 16'h0000, 16'h005A, 1'b0, 3, 8'h5A, 8'h3C};
        tbl[11] = '{1'b0, 16'h0104, 16'h0000, 16'h00FF, 1'b0, 3, 8'h5A, 8'h3C};
        tbl[12] = '{1'b1, 16'h0104, 16'h00FF, 16'h0000, 1'b0, 3, 8'h5A, 8'h3C};
        tbl[13] = '{1'b0, 16'h0104, 16'h0000, 16'h0000, 1'b0, 3, 8'h5A, 8'h3C};
        tbl[14] = '{1'b1, 16'h0105, 16'h0080, 16'h0000, 1'b0, 3, 8'h5A, 8'h3C};
        tbl[15] = '{1'b0, 16'h0105, 16'h0000, 16'h0080, 1'b0, 3, 8'h5A, 8'h3C};
        tbl[16] = '{1'b1, 16'h0103, 16'h0001, 16'h0000, 1'b0, 3, 8'h5A, 8'h3C};
        tbl[17] = '{1'b0, 16'h0103, 16'h0000, 16'h0001, 1'b0, 3, 8'h5A, 8'h3C};
        tbl[18] = '{1'b0, 16'h0200, 16'h0000, 16'h0000, 1'b0, 0, 8'h5A, 8'h3C};

        tick(3);
        chk("reset PORT_OUT", PORT_OUT, 8'h00);
        chk("reset PORT_OE", PORT_OE, 8'h00);
        chk("reset IRQ", IRQ, 1'b0);
        chk("reset PREADY", PREADY, 1'b0);
        chk("reset PRDATA", PRDATA, 16'h0000);
        RST = 1'b1;
        tick(4);

        for (int i = 0; i < 19; i++) begin
            apb(tbl[i].w, tbl[i].a, tbl[i].d, rd, e, rc);
            chk($sformatf("row%0d ready cycle", i), rc, tbl[i].rc);
            if (tbl[i].rc != 0) chk($sformatf("row%0d PSLVERR", i), e, tbl[i].err);
            if (!tbl[i].w && tbl[i].rc != 0) chk($sformatf("row%0d PRDATA", i), rd, tbl[i].rd);
            chk($sformatf("row%0d PORT_OUT", i), PORT_OUT, tbl[i].out);
            chk($sformatf("row%0d PORT_OE", i), PORT_OE, tbl[i].oe);
            chk($sformatf("row%0d PREADY after", i), PREADY, 1'b0);
            chk($sformatf("row%0d IRQ", i), IRQ, 1'b0);
        end

        // rising event on bit 0 with IEN[0]=1: IRQ rises on the third edge
        PORT_IN = 8'hFE;
        tick(4);
        PORT_IN = 8'hFF;
        tick(2);
        chk("rise IRQ edge2", IRQ, 1'b0);
        tick(1);
        chk("rise IRQ edge3", IRQ, 1'b1);
        apb(1'b0, 16'h0104, 16'h0000, rd, e, rc);
        chk("rise ISTAT", rd, 16'h0001);
        apb(1'b1, 16'h0104, 16'h0001, rd, e, rc);
        chk("w1c IRQ low", IRQ, 1'b0);

        // falling event on bit 7 while masked, then unmasked by an IEN write
        apb(1'b1, 16'h0103, 16'h0000, rd, e, rc);
        PORT_IN = 8'h7F;
        tick(4);
        chk("masked IRQ", IRQ, 1'b0);
        apb(1'b0, 16'h0104, 16'h0000, rd, e, rc);
        chk("fall ISTAT", rd, 16'h0080);
        apb(1'b1, 16'h0103, 16'h0080, rd, e, rc);
        chk("unmask IRQ", IRQ, 1'b1);

        // set beats clear: W1C on bit 0 whose ready edge coincides with a new rising event
        apb(1'b1, 16'h0104, 16'h0080, rd, e, rc);
        chk("clear bit7 IRQ", IRQ, 1'b0);
        apb(1'b1, 16'h0103, 16'h0001, rd, e, rc);
        PORT_IN = 8'h7E;
        tick(4);
        PORT_IN = 8'h7F;
        tick(4);
        chk("bit0 armed IRQ", IRQ, 1'b1);
        PORT_IN = 8'h7E;
        tick(4);
        PORT_IN = 8'h7F;
        apb(1'b1, 16'h0104, 16'h0001, rd, e, rc);
        chk("set beats clear IRQ", IRQ, 1'b1);
        apb(1'b0, 16'h0104, 16'h0000, rd, e, rc);
        chk("set beats clear ISTAT", rd, 16'h0001);

        // reset asserted during the ready cycle aborts the write
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'h0100; PWDATA = 16'h0033;
        tick(1);
        PENABLE = 1'b1;
        tick(1);
        chk("pre-reset PREADY", PREADY, 1'b1);
        RST = 1'b0;
        #1;
        chk("mid reset PREADY", PREADY, 1'b0);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        tick(1);
        RST = 1'b1;
        tick(2);
        chk("post reset PORT_OUT", PORT_OUT, 8'h00);
        chk("post reset PREADY", PREADY, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
